// File: rtl/sm_reg_scanner_if.sv
// Register-file read port plus hex-display feed between the scanner and the rest of the board.
interface sm_reg_scanner_if;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [31:0] disp_number;
  logic [4:0]  disp_addr;
  logic        disp_update;

  modport master (
    output reg_addr,
    input  reg_data,
    output disp_number,
    output disp_addr,
    output disp_update
  );

  modport slave (
    input  reg_addr,
    output reg_data,
    input  disp_number,
    input  disp_addr,
    input  disp_update
  );
endinterface

// File: rtl/sm_reg_scanner.sv
// Board debug scanner: debounced keys step the register address, a settle/capture/hold FSM
// feeds the hex display, and the run key toggles the CPU clock enable.
//
// state      | meaning
// ST_SETTLE  | address just changed, waiting for regData to settle
// ST_CAPTURE | latch regData/regAddr into the display registers
// ST_HOLD    | display valid, timing the next refresh capture
module sm_reg_scanner #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd50000,
  parameter logic [3:0]  SETTLE_CYCLES   = 4'd4,
  parameter logic [23:0] REFRESH_CYCLES  = 24'd1000000,
  parameter logic [27:0] SCAN_CYCLES     = 28'd50000000,
  parameter logic [4:0]  ADDR_MAX        = 5'd31,
  parameter logic        RUN_ON_RESET    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_next_n_i,
  input  logic             btn_prev_n_i,
  input  logic             btn_run_n_i,
  input  logic             scan_auto_i,
  output logic             clk_enable_o,
  sm_reg_scanner_if.master bus
);

  typedef enum logic [1:0] {ST_SETTLE, ST_CAPTURE, ST_HOLD} state_t;

  // bit order: {scan_auto, run, prev, next}; buttons idle high
  logic [3:0]  meta_q, sync_q;
  logic [2:0]  btn_acc_q;
  logic [2:0]  press_q;
  logic [19:0] deb_cnt_q [3];

  logic [4:0]  addr_q, addr_d, addr_inc, addr_dec;
  logic        clk_enable_q;
  logic        scan_prev_q;
  logic [27:0] scan_cnt_q;

  state_t      state_q;
  logic [3:0]  settle_cnt_q;
  logic [23:0] refresh_cnt_q;
  logic [31:0] disp_number_q;
  logic [4:0]  disp_addr_q;
  logic        disp_update_q;

  logic next_ev, prev_ev, run_ev, scan_lvl, scan_tick, addr_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'b0111;
      sync_q <= 4'b0111;
    end else begin
      meta_q <= {scan_auto_i, btn_run_n_i, btn_prev_n_i, btn_next_n_i};
      sync_q <= meta_q;
    end
  end

  // Counter only runs while the synchronized level differs from the accepted one,
  // so any bounce back to the accepted level restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_acc_q <= 3'b111;
      press_q   <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        press_q[i] <= 1'b0;
        if (sync_q[i] == btn_acc_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] >= DEBOUNCE_CYCLES - 20'd1) begin
          deb_cnt_q[i] <= '0;
          btn_acc_q[i] <= sync_q[i];
          press_q[i]   <= ~sync_q[i];
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 20'd1;
        end
      end
    end
  end

  assign next_ev   = press_q[0];
  assign prev_ev   = press_q[1];
  assign run_ev    = press_q[2];
  assign scan_lvl  = sync_q[3];
  assign scan_tick = scan_lvl && scan_prev_q && (scan_cnt_q >= SCAN_CYCLES - 28'd1);

  assign addr_inc = (addr_q >= ADDR_MAX) ? 5'd0 : addr_q + 5'd1;
  assign addr_dec = (addr_q == 5'd0) ? ADDR_MAX : addr_q - 5'd1;

  always_comb begin
    addr_d = addr_q;
    if (next_ev && !prev_ev)       addr_d = addr_inc;
    else if (prev_ev && !next_ev)  addr_d = addr_dec;
    else if (!next_ev && !prev_ev && scan_tick) addr_d = addr_inc;
  end

  assign addr_chg = (addr_d != addr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= 5'd0;
      clk_enable_q <= RUN_ON_RESET;
      scan_prev_q  <= 1'b0;
      scan_cnt_q   <= '0;
    end else begin
      addr_q      <= addr_d;
      scan_prev_q <= scan_lvl;
      if (run_ev) clk_enable_q <= ~clk_enable_q;
      // a manual event on the tick cycle swallows the tick and restarts the period
      if (!scan_lvl || !scan_prev_q || addr_chg || next_ev || prev_ev || scan_tick)
        scan_cnt_q <= '0;
      else
        scan_cnt_q <= scan_cnt_q + 28'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SETTLE;
      settle_cnt_q  <= '0;
      refresh_cnt_q <= '0;
      disp_number_q <= '0;
      disp_addr_q   <= '0;
      disp_update_q <= 1'b0;
    end else begin
      disp_update_q <= 1'b0;
      if (addr_chg) begin
        state_q       <= ST_SETTLE;
        settle_cnt_q  <= '0;
        refresh_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_SETTLE: begin
            if (settle_cnt_q >= SETTLE_CYCLES - 4'd1) begin
              state_q      <= ST_CAPTURE;
              settle_cnt_q <= '0;
            end else begin
              settle_cnt_q <= settle_cnt_q + 4'd1;
            end
          end
          ST_CAPTURE: begin
            disp_number_q <= bus.reg_data;
            disp_addr_q   <= addr_q;
            disp_update_q <= 1'b1;
            refresh_cnt_q <= '0;
            state_q       <= ST_HOLD;
          end
          ST_HOLD: begin
            if (refresh_cnt_q >= REFRESH_CYCLES - 24'd1) begin
              state_q       <= ST_CAPTURE;
              refresh_cnt_q <= '0;
            end else begin
              refresh_cnt_q <= refresh_cnt_q + 24'd1;
            end
          end
          default: state_q <= ST_SETTLE;
        endcase
      end
    end
  end

  assign bus.reg_addr    = addr_q;
  assign bus.disp_number = disp_number_q;
  assign bus.disp_addr   = disp_addr_q;
  assign bus.disp_update = disp_update_q;
  assign clk_enable_o    = clk_enable_q;

endmodule

// File: tb/tb_sm_reg_scanner.sv
// Self-checking bench for sm_reg_scanner: directed key/scan scenarios plus random key presses
// against an address/run/register-memory reference model.
module tb_sm_reg_scanner;
  localparam int DEB     = 4;
  localparam int SETTLE  = 2;
  localparam int REFRESH = 16;
  localparam int SCAN    = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_next_n = 1'b1, btn_prev_n = 1'b1, btn_run_n = 1'b1, scan_auto = 1'b0;
  logic clk_enable;
  logic [31:0] mem [32];

  int n_checks = 0;
  int n_errors = 0;
  int model_addr = 0;
  logic model_run = 1'b1;
  int cyc = 0, upd_last = 0, upd_period = 0;
  int press_lat = 7;

  sm_reg_scanner_if bus();
  assign bus.reg_data = mem[bus.reg_addr];

  sm_reg_scanner #(
    .DEBOUNCE_CYCLES(20'd4),
    .SETTLE_CYCLES  (4'd2),
    .REFRESH_CYCLES (24'd16),
    .SCAN_CYCLES    (28'd32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_next_n_i(btn_next_n),
    .btn_prev_n_i(btn_prev_n),
    .btn_run_n_i (btn_run_n),
    .scan_auto_i (scan_auto),
    .clk_enable_o(clk_enable),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.disp_update) begin
      upd_period = cyc - upd_last;
      upd_last   = cyc;
    end
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic press(input logic nx, input logic pv, input logic rn, input string tag);
    @(negedge clk);
    btn_next_n = ~nx;
    btn_prev_n = ~pv;
    btn_run_n  = ~rn;
    repeat (3*DEB) @(negedge clk);
    btn_next_n = 1'b1;
    btn_prev_n = 1'b1;
    btn_run_n  = 1'b1;
    repeat (3*DEB) @(negedge clk);
    if (nx && !pv)      model_addr = (model_addr + 1) % 32;
    else if (pv && !nx) model_addr = (model_addr + 31) % 32;
    if (rn) model_run = ~model_run;
    check_val({tag, "_addr"}, {27'd0, bus.reg_addr}, model_addr);
    check_val({tag, "_run"}, {31'd0, clk_enable}, {31'd0, model_run});
  endtask

  task automatic wait_update(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < REFRESH + SETTLE + 8 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bus.disp_update) seen = 1'b1;
    end
    check_val({tag, "_upd_seen"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    logic seen;
    int lat;
    int op;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;

    // reset values
    repeat (3) @(negedge clk);
    check_val("rst_addr", {27'd0, bus.reg_addr}, 32'd0);
    check_val("rst_run", {31'd0, clk_enable}, 32'd1);
    check_val("rst_upd", {31'd0, bus.disp_update}, 32'd0);
    check_val("rst_num", bus.disp_number, 32'd0);
    check_val("rst_daddr", {27'd0, bus.disp_addr}, 32'd0);
    rst_n = 1'b1;
    wait_update("boot");
    check_val("boot_num", bus.disp_number, mem[0]);

    // bouncing next key: one step only
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      btn_next_n = ~btn_next_n;
      repeat (2) @(negedge clk);
    end
    btn_next_n = 1'b0;
    repeat (3*DEB) @(negedge clk);
    btn_next_n = 1'b1;
    repeat (3*DEB) @(negedge clk);
    model_addr = 1;
    check_val("bounce_addr", {27'd0, bus.reg_addr}, model_addr);

    // wrap in both directions, simultaneous next+prev
    press(1'b0, 1'b1, 1'b0, "prev_1to0");
    press(1'b0, 1'b1, 1'b0, "prev_wrap");
    press(1'b1, 1'b0, 1'b0, "next_wrap");
    press(1'b0, 1'b1, 1'b0, "prev_wrap2");
    press(1'b1, 1'b1, 1'b0, "both");

    // capture latency and refresh
    mem[5] = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0, "to_addr4");
    @(negedge clk);
    btn_next_n = 1'b0;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (i == 3*DEB) btn_next_n = 1'b1;
      if (seen) lat++;
      else if (bus.reg_addr == 5'd5) begin
        seen = 1'b1;
        lat = 1;
        press_lat = i + 1;
      end
      if (seen && lat == SETTLE + 1) check_val("cap_early", {31'd0, bus.disp_update}, 32'd0);
      if (seen && lat == SETTLE + 2) begin
        check_val("cap_latency", {31'd0, bus.disp_update}, 32'd1);
        check_val("cap_num", bus.disp_number, 32'hDEADBEEF);
        check_val("cap_daddr", {27'd0, bus.disp_addr}, 32'd5);
      end
      if (seen && lat == SETTLE + 3) check_val("cap_width", {31'd0, bus.disp_update}, 32'd0);
    end
    check_val("cap_seen", {31'd0, seen}, 32'd1);
    model_addr = 5;
    mem[5] = 32'h12345678;
    wait_update("refresh");
    check_val("refresh_num", bus.disp_number, 32'h12345678);
    check_val("refresh_period", upd_period, REFRESH + 1);

    // auto-scan from address 0
    for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 1'b0, "to_addr0");
    scan_auto = 1'b1;
    repeat (100) @(negedge clk);
    // timer starts after two sync flops plus the enable edge detect
    model_addr = (model_addr + (100 - 3) / SCAN) % 32;
    check_val("auto_addr", {27'd0, bus.reg_addr}, model_addr);
    // manual next landing on the next tick edge
    repeat ((3 + 4*SCAN) - press_lat - 100) @(negedge clk);
    btn_next_n = 1'b0;
    repeat (3*DEB) @(negedge clk);
    btn_next_n = 1'b1;
    repeat (3*DEB) @(negedge clk);
    model_addr = (model_addr + 1) % 32;
    check_val("tick_manual", {27'd0, bus.reg_addr}, model_addr);
    scan_auto = 1'b0;
    repeat (40) @(negedge clk);
    check_val("scan_off_hold", {27'd0, bus.reg_addr}, model_addr);

    // run toggle while refresh cadence continues
    fork
      begin
        press(1'b0, 1'b0, 1'b1, "run_stop");
        press(1'b0, 1'b0, 1'b1, "run_go");
      end
      begin
        for (int k = 0; k < 4; k++) begin
          wait_update("run_cad");
          check_val("run_period", upd_period, REFRESH + 1);
          check_val("run_num", bus.disp_number, mem[model_addr]);
        end
      end
    join

    // random key presses
    for (int n = 0; n < 24; n++) begin
      mem[$urandom_range(0, 31)] = $urandom;
      op = $urandom_range(0, 3);
      case (op)
        0: press(1'b1, 1'b0, 1'b0, "rnd_next");
        1: press(1'b0, 1'b1, 1'b0, "rnd_prev");
        2: press(1'b1, 1'b1, 1'b0, "rnd_both");
        default: press(1'b0, 1'b0, 1'b1, "rnd_run");
      endcase
      wait_update("rnd");
      check_val("rnd_num", bus.disp_number, mem[model_addr]);
      check_val("rnd_daddr", {27'd0, bus.disp_addr}, model_addr);
    end

    // reset while settling on address 7
    for (int i = 0; i < 32 && model_addr != 6; i++) press(1'b1, 1'b0, 1'b0, "to_addr6");
    @(negedge clk);
    btn_next_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.reg_addr == 5'd7) seen = 1'b1;
    end
    check_val("rst7_seen", {31'd0, seen}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rst7_addr", {27'd0, bus.reg_addr}, 32'd0);
    check_val("rst7_run", {31'd0, clk_enable}, 32'd1);
    check_val("rst7_upd", {31'd0, bus.disp_update}, 32'd0);
    btn_next_n = 1'b1;
    model_addr = 0;
    model_run = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_update("post_rst");
    check_val("post_rst_num", bus.disp_number, mem[0]);
    check_val("post_rst_daddr", {27'd0, bus.disp_addr}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
